id_ex_alu_ctrl: RTL and testbench

ID/EX pipeline stage of the RISC-V pipeline. It is the producing end of the ALU interface. It decodes the instruction fields presented in ID into the 3-bit ALU operation code, selects both ALU operands, and registers everything into the ID/EX boundary. The EX stage drives the ALU straight from these registered outputs, with no further decode. Pipeline control is stall/flush, issued by the hazard unit.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_decoder.sv | 82 ++++++++
 rtl/id_ex_alu_ctrl.sv | 115 +++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ID/EX ALU control stage: ALU operation codes,
// RISC-V major opcodes and the operand-select encodings used by the decoder.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] BUBBLE_OPC = ALU_ADD;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7b5 into the ALU operation,
// operand selects and branch/illegal flags.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] opc,
    output a_sel_e     a_sel,
    output b_sel_e     b_sel,
    output logic       branch,
    output logic       br_inv,
    output logic       illegal
);

    always_comb begin
        opc     = ALU_ADD;
        a_sel   = A_RS1;
        b_sel   = B_IMM;
        branch  = 1'b0;
        br_inv  = 1'b0;
        illegal = 1'b0;

        case (opcode)
            OP, OP_IMM: begin
                b_sel = (opcode == OP) ? B_RS2 : B_IMM;
                case (funct3)
                    3'b000:  opc = (opcode == OP && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  opc = ALU_AND;
                    3'b110:  opc = ALU_OR;
                    3'b100:  opc = ALU_XOR;
                    3'b010:  opc = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            LOAD, STORE, JALR: begin
                opc   = ALU_ADD;
                b_sel = B_IMM;
            end
            BRANCH: begin
                b_sel  = B_RS2;
                branch = 1'b1;
                case (funct3)
                    3'b000: opc = ALU_SUB;
                    3'b001: begin
                        opc    = ALU_SUB;
                        br_inv = 1'b1;
                    end
                    3'b100: opc = ALU_SLT;
                    3'b101: begin
                        opc    = ALU_SLT;
                        br_inv = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            LUI: begin
                a_sel = A_ZERO;
                b_sel = B_IMM;
            end
            AUIPC: begin
                a_sel = A_PC;
                b_sel = B_IMM;
            end
            JAL: begin
                a_sel = A_PC;
                b_sel = B_FOUR;
            end
            default: illegal = 1'b1;
        endcase

        // An illegal encoding must not leak partial decode into EX.
        if (illegal) begin
            opc    = ALU_ADD;
            a_sel  = A_ZERO;
            branch = 1'b0;
            br_inv = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX stage register for the ALU interface: decodes the ID instruction,
// muxes both operands and registers them with reset > flush > stall priority.
module id_ex_alu_ctrl
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic [N-1:0] pc,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    output logic         ex_valid,
    output logic [2:0]   alu_opc,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [N-1:0] ex_rs2_data,
    output logic [N-1:0] ex_pc,
    output logic         ex_branch,
    output logic         ex_br_inv,
    output logic         ex_illegal
);

    logic [2:0]   w_opc;
    a_sel_e       w_a_sel;
    b_sel_e       w_b_sel;
    logic         w_branch;
    logic         w_br_inv;
    logic         w_illegal;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;

    logic         r_valid;
    logic [2:0]   r_opc;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_rs2;
    logic [N-1:0] r_pc;
    logic         r_branch;
    logic         r_br_inv;
    logic         r_illegal;

    alu_decoder u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .opc      (w_opc),
        .a_sel    (w_a_sel),
        .b_sel    (w_b_sel),
        .branch   (w_branch),
        .br_inv   (w_br_inv),
        .illegal  (w_illegal)
    );

    always_comb begin
        w_a = '0;
        case (w_a_sel)
            A_RS1:   w_a = rs1_data;
            A_PC:    w_a = pc;
            default: w_a = '0;
        endcase

        w_b = '0;
        case (w_b_sel)
            B_RS2:   w_b = rs2_data;
            B_IMM:   w_b = imm;
            B_FOUR:  w_b = N'(4);
            default: w_b = '0;
        endcase
        // The select encoding has no zero for b, so illegal forces it here.
        if (w_illegal) w_b = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_valid   <= 1'b0;
            r_opc     <= BUBBLE_OPC;
            r_a       <= '0;
            r_b       <= '0;
            r_rs2     <= '0;
            r_pc      <= '0;
            r_branch  <= 1'b0;
            r_br_inv  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            r_valid   <= in_valid;
            r_opc     <= w_opc;
            r_a       <= w_a;
            r_b       <= w_b;
            r_rs2     <= rs2_data;
            r_pc      <= pc;
            r_branch  <= w_branch & in_valid;
            r_br_inv  <= w_br_inv;
            r_illegal <= w_illegal & in_valid;
        end
    end

    assign ex_valid    = r_valid;
    assign alu_opc     = r_opc;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign ex_rs2_data = r_rs2;
    assign ex_pc       = r_pc;
    assign ex_branch   = r_branch;
    assign ex_br_inv   = r_br_inv;
    assign ex_illegal  = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Randomized bench for id_ex_alu_ctrl against a table-driven reference model,
// with directed literal checks for the decode corners and stall/flush/reset.
module tb_id_ex_alu_ctrl;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic [N-1:0] pc;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [N-1:0] imm;
    logic         ex_valid;
    logic [2:0]   alu_opc;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] ex_rs2_data;
    logic [N-1:0] ex_pc;
    logic         ex_branch;
    logic         ex_br_inv;
    logic         ex_illegal;

    typedef struct packed {
        logic         valid;
        logic [2:0]   opc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] rs2;
        logic [N-1:0] pc;
        logic         br;
        logic         inv;
        logic         ill;
    } exp_t;

    int   vectors;
    int   miscompares;
    exp_t m;

    id_ex_alu_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .ex_valid    (ex_valid),
        .alu_opc     (alu_opc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .ex_rs2_data (ex_rs2_data),
        .ex_pc       (ex_pc),
        .ex_branch   (ex_branch),
        .ex_br_inv   (ex_br_inv),
        .ex_illegal  (ex_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what EX should hold after capturing this ID instruction.
    function automatic exp_t model(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic [N-1:0] p, input logic [N-1:0] r1,
                                   input logic [N-1:0] r2, input logic [N-1:0] im);
        exp_t e;
        logic bad;
        e = '0;
        bad = 1'b0;
        e.rs2 = r2;
        e.pc  = p;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            e.a = r1;
            e.b = (op == 7'b0110011) ? r2 : im;
            if (f3 == 3'd0)      e.opc = (op == 7'b0110011 && f7) ? 3'd1 : 3'd0;
            else if (f3 == 3'd7) e.opc = 3'd2;
            else if (f3 == 3'd6) e.opc = 3'd3;
            else if (f3 == 3'd4) e.opc = 3'd4;
            else if (f3 == 3'd2) e.opc = 3'd5;
            else bad = 1'b1;
        end else if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100111) begin
            e.a = r1;
            e.b = im;
        end else if (op == 7'b1100011) begin
            e.a  = r1;
            e.b  = r2;
            e.br = 1'b1;
            if (f3 == 3'd0 || f3 == 3'd1)      e.opc = 3'd1;
            else if (f3 == 3'd4 || f3 == 3'd5) e.opc = 3'd5;
            else bad = 1'b1;
            e.inv = (f3 == 3'd1 || f3 == 3'd5);
        end else if (op == 7'b0110111) begin
            e.b = im;
        end else if (op == 7'b0010111) begin
            e.a = p;
            e.b = im;
        end else if (op == 7'b1101111) begin
            e.a = p;
            e.b = 4;
        end else begin
            bad = 1'b1;
        end
        if (bad) begin
            e.opc = 3'd0;
            e.a   = '0;
            e.b   = '0;
            e.br  = 1'b0;
            e.inv = 1'b0;
        end
        e.valid = v;
        e.br    = e.br & v;
        e.ill   = bad & v;
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst || flush) m = '0;
        else if (!stall)   m = model(in_valid, opcode, funct3, funct7b5, pc, rs1_data, rs2_data, imm);
    end

    always @(negedge clk) begin
        exp_t d;
        d = {ex_valid, alu_opc, alu_a, alu_b, ex_rs2_data, ex_pc, ex_branch, ex_br_inv, ex_illegal};
        vectors++;
        if (d !== m) begin
            miscompares++;
            $display("FAIL model t=%0t dut=%h expected=%h", $time, d, m);
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [N-1:0] p, input logic [N-1:0] r1,
                           input logic [N-1:0] r2, input logic [N-1:0] im);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        pc       = p;
        rs1_data = r1;
        rs2_data = r2;
        imm      = im;
    endtask

    task automatic rand_ins();
        set_ins(7'($urandom), 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    endtask

    logic [6:0] ops [10];

    initial begin
        vectors     = 0;
        miscompares = 0;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        rand_ins();
        tick();
        rand_ins();
        tick();
        chk("reset_valid", 32'(ex_valid), 0);
        chk("reset_opc", 32'(alu_opc), 0);
        chk("reset_a", alu_a, 0);
        chk("reset_b", alu_b, 0);
        chk("reset_pc", ex_pc, 0);

        rst = 1'b1;
        set_ins(7'b0110011, 3'b000, 1'b1, 32'h10, 7, 9, 32'h77);
        tick();
        chk("sub_valid", 32'(ex_valid), 1);
        chk("sub_opc", 32'(alu_opc), 1);
        chk("sub_a", alu_a, 7);
        chk("sub_b", alu_b, 9);
        set_ins(7'b0110011, 3'b010, 1'b0, 32'h14, 7, 9, 32'h77);
        tick();
        chk("slt_opc", 32'(alu_opc), 5);
        set_ins(7'b0110011, 3'b011, 1'b0, 32'h18, 7, 9, 32'h77);
        tick();
        chk("r011_illegal", 32'(ex_illegal), 1);
        chk("r011_valid", 32'(ex_valid), 1);
        chk("r011_a", alu_a, 0);
        set_ins(7'b0010011, 3'b000, 1'b1, 32'h1c, 3, 9, 32'h55);
        tick();
        chk("addi_opc", 32'(alu_opc), 0);
        chk("addi_b", alu_b, 32'h55);
        set_ins(7'b0110111, 3'b101, 1'b0, 32'h20, 32'hdead, 9, 32'h12345000);
        tick();
        chk("lui_a", alu_a, 0);
        chk("lui_b", alu_b, 32'h12345000);
        set_ins(7'b0010111, 3'b000, 1'b0, 32'h40, 32'hbeef, 9, 32'h1000);
        tick();
        chk("auipc_a", alu_a, 32'h40);
        set_ins(7'b1101111, 3'b000, 1'b0, 32'h100, 32'hbeef, 9, 32'h800);
        tick();
        chk("jal_a", alu_a, 32'h100);
        chk("jal_b", alu_b, 4);
        set_ins(7'b1100011, 3'b101, 1'b0, 32'h104, 11, 22, 32'h8);
        tick();
        chk("bge_opc", 32'(alu_opc), 5);
        chk("bge_branch", 32'(ex_branch), 1);
        chk("bge_inv", 32'(ex_br_inv), 1);
        set_ins(7'b1100011, 3'b001, 1'b0, 32'h108, 11, 22, 32'h8);
        tick();
        chk("bne_opc", 32'(alu_opc), 1);
        chk("bne_inv", 32'(ex_br_inv), 1);
        set_ins(7'b1100011, 3'b010, 1'b0, 32'h10c, 11, 22, 32'h8);
        tick();
        chk("br010_illegal", 32'(ex_illegal), 1);
        chk("br010_branch", 32'(ex_branch), 0);

        set_ins(7'b1100011, 3'b100, 1'b0, 32'h110, 33, 44, 32'h8);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ins();
            tick();
            chk("stall_opc", 32'(alu_opc), 5);
            chk("stall_a", alu_a, 33);
            chk("stall_pc", ex_pc, 32'h110);
        end
        flush = 1'b1;
        tick();
        chk("flushstall_valid", 32'(ex_valid), 0);
        chk("flushstall_a", alu_a, 0);
        stall = 1'b0;
        tick();
        flush = 1'b0;
        set_ins(7'b0010011, 3'b100, 1'b0, 32'h200, 5, 6, 32'h0f);
        tick();
        chk("postflush_opc", 32'(alu_opc), 4);
        chk("postflush_b", alu_b, 32'h0f);
        chk("postflush_valid", 32'(ex_valid), 1);

        in_valid = 1'b0;
        set_ins(7'b0110011, 3'b000, 1'b0, 32'h204, 5, 6, 32'h0f);
        tick();
        chk("inv_valid", 32'(ex_valid), 0);
        chk("inv_illegal", 32'(ex_illegal), 0);
        chk("inv_branch", 32'(ex_branch), 0);

        for (int i = 0; i < 3000; i++) begin
            rand_ins();
            opcode   = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) opcode = 7'($urandom);
            rst      = ($urandom_range(0, 49) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 6) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
